// File: rtl/divider_seq.sv
// Multi-cycle signed radix-2 non-restoring divider producing {remainder, quotient}.
// Optional macro DIVIDER_DBZ_FLAG_EN adds a registered divide-by-zero flag output (dbz).
module divider_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    output logic                 dbz
`endif
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned RW    = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [RW-1:0]        r_q, r_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 zero_q, zero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   c_q, c_d;

    logic [RW-1:0]        b_ext;
    logic [RW-1:0]        r_sh;
    logic [RW-1:0]        r_step;
    logic [WIDTH-1:0]     r_fix;
    logic [WIDTH-1:0]     q_fin;
    logic [WIDTH-1:0]     r_fin;

    // Datapath: one non-restoring step plus the final sign correction.
    // With a zero divisor the iteration leaves R=|A| and Q=all ones, so the
    // dividend-sign negation of R reproduces raw A; only the Q negation is skipped.
    always_comb begin
        b_ext  = {1'b0, b_q};
        r_sh   = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
        r_step = r_q[WIDTH] ? (r_sh + b_ext) : (r_sh - b_ext);
        r_fix  = r_q[WIDTH-1:0] + (r_q[WIDTH] ? b_q : WIDTH'(0));
        q_fin  = ((sign_a_q ^ sign_b_q) && !zero_q) ? (WIDTH'(0) - a_q) : a_q;
        r_fin  = sign_a_q ? (WIDTH'(0) - r_fix) : r_fix;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        c_d      = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    sign_a_d = A[WIDTH-1];
                    sign_b_d = B[WIDTH-1];
                    busy_d   = 1'b1;
                    state_d  = PREP;
                end
            end
            PREP: begin
                a_d     = sign_a_q ? (WIDTH'(0) - a_q) : a_q;
                b_d     = sign_b_q ? (WIDTH'(0) - b_q) : b_q;
                zero_d  = (b_q == WIDTH'(0));
                r_d     = RW'(0);
                cnt_d   = CNT_W'(0);
                state_d = ITER;
            end
            ITER: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = FIX;
                end else begin
                    r_d   = r_step;
                    a_d   = {a_q[WIDTH-2:0], ~r_step[WIDTH]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                c_d     = {r_fin, q_fin};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            c_q      <= c_d;
        end
    end

`ifdef DIVIDER_DBZ_FLAG_EN
    logic dbz_q;

    // Flag tracks the divisor of the most recently completed operation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dbz_q <= 1'b0;
        end else if (state_q == FIX) begin
            dbz_q <= zero_q;
        end
    end

    assign dbz = dbz_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: scoreboard of expected {R,Q} words checked on each done.
module tb_divider_seq;
    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = WIDTH + 3;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] C;
`ifdef DIVIDER_DBZ_FLAG_EN
    logic        dbz;
`endif

    int passed = 0;
    int total  = 0;

    logic [63:0] exp_c_q[$];
    logic        exp_dbz_q[$];

    always #5 clk = ~clk;

    divider_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .C     (C)
`ifdef DIVIDER_DBZ_FLAG_EN
        ,
        .dbz   (dbz)
`endif
    );

    // Reference: 64-bit signed arithmetic truncates toward zero and avoids the overflow trap.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic expect_op(input logic [31:0] a, input logic [31:0] b);
        exp_c_q.push_back(model(a, b));
        exp_dbz_q.push_back(b == 32'h0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom();
        B     = $urandom();
    endtask

    task automatic wait_result(input string name, input int edges_before);
        int          n;
        int          busy_low;
        logic        got;
        logic [63:0] exp_c;
        logic        exp_d;
        n        = edges_before;
        busy_low = 0;
        got      = 1'b0;
        while (!got && n < LAT + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
            else if (!busy) busy_low++;
        end
        exp_c = (exp_c_q.size() > 0) ? exp_c_q.pop_front() : 64'h0;
        exp_d = (exp_dbz_q.size() > 0) ? exp_dbz_q.pop_front() : 1'b0;
        total++;
        if (n !== LAT) $display("FAIL %s latency: got %0d edges, want %0d", name, n, LAT);
        else passed++;
        total++;
        if (busy_low !== 0 || busy !== 1'b0)
            $display("FAIL %s busy: low_cycles=%0d busy_at_done=%b, want 0/0", name, busy_low, busy);
        else passed++;
        total++;
        if (C !== exp_c) $display("FAIL %s C: got %h, want %h", name, C, exp_c);
        else passed++;
`ifdef DIVIDER_DBZ_FLAG_EN
        total++;
        if (dbz !== exp_d) $display("FAIL %s dbz: got %b, want %b", name, dbz, exp_d);
        else passed++;
`endif
    endtask

    task automatic test_reset();
        clr   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b, want 0", busy); else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset done: got %b, want 0", done); else passed++;
        total++;
        if (C !== 64'h0) $display("FAIL reset C: got %h, want 0", C); else passed++;
`ifdef DIVIDER_DBZ_FLAG_EN
        total++;
        if (dbz !== 1'b0) $display("FAIL reset dbz: got %b, want 0", dbz); else passed++;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        exp_c_q.push_back(64'h00000002_0000000E);
        exp_dbz_q.push_back(1'b0);
        issue(32'd100, 32'd7);
        wait_result("basic_100_7", 0);
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) $display("FAIL done_pulse: got %b, want 0", done); else passed++;
        total++;
        if (C !== 64'h00000002_0000000E) $display("FAIL c_hold: got %h, want 000000020000000e", C);
        else passed++;
    endtask

    task automatic test_signs();
        exp_c_q.push_back(64'hFFFFFFFE_FFFFFFF2);
        exp_dbz_q.push_back(1'b0);
        issue(32'hFFFFFF9C, 32'd7);
        wait_result("neg_dividend", 0);
        exp_c_q.push_back(64'h00000002_FFFFFFF2);
        exp_dbz_q.push_back(1'b0);
        issue(32'd100, 32'hFFFFFFF9);
        wait_result("neg_divisor", 0);
    endtask

    task automatic test_dbz();
        exp_c_q.push_back(64'h00000005_FFFFFFFF);
        exp_dbz_q.push_back(1'b1);
        issue(32'd5, 32'd0);
        wait_result("div_by_zero", 0);
        exp_c_q.push_back(64'h00000000_00000003);
        exp_dbz_q.push_back(1'b0);
        issue(32'd9, 32'd3);
        wait_result("after_dbz_9_3", 0);
    endtask

    task automatic test_overflow();
        exp_c_q.push_back(64'h00000000_80000000);
        exp_dbz_q.push_back(1'b0);
        issue(32'h80000000, 32'hFFFFFFFF);
        wait_result("overflow", 0);
        exp_c_q.push_back(64'h0);
        exp_dbz_q.push_back(1'b0);
        issue(32'd0, 32'd5);
        wait_result("zero_dividend", 0);
    endtask

    task automatic test_busy_ignore();
        exp_c_q.push_back(64'h00000002_0000000E);
        exp_dbz_q.push_back(1'b0);
        issue(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        issue(32'd8, 32'd2);
        wait_result("start_while_busy", 10);
    endtask

    task automatic test_back_to_back();
        expect_op(32'd8, 32'd2);
        issue(32'd8, 32'd2);
        wait_result("start_on_done", 0);
    endtask

    task automatic test_clr_abort();
        logic saw_done;
        issue(32'd100, 32'd7);
        repeat (11) @(posedge clk);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL clr_busy: got %b, want 0", busy); else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL clr_done: got %b, want 0", done); else passed++;
        total++;
        if (C !== 64'h0) $display("FAIL clr_c: got %h, want 0", C); else passed++;
        @(negedge clk);
        clr = 1'b0;
        saw_done = 1'b0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) $display("FAIL clr_no_done: got done=%b, want 0", saw_done);
        else passed++;
        exp_c_q.push_back(64'h00000000_0000000A);
        exp_dbz_q.push_back(1'b0);
        issue(32'd50, 32'd5);
        wait_result("after_clr_50_5", 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom();
            b = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 1000)));
            if (i == 5) b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            expect_op(a, b);
            issue(a, b);
            wait_result($sformatf("random_%0d", i), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_dbz();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_clr_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Multi-cycle signed 32-bit divider that produces the 64-bit {remainder, quotient} word the ALU drives onto its C output for the DIV operation.
- Sits beside the multiplier and adders as an ALU operand-consuming unit.
- Control unit pulses start with A/B valid, waits for done, then latches C into Z (HI = remainder, LO = quotient).
- Radix-2 non-restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width in bits. C is 2*WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request; A/B sampled on the same edge.
- A  input  WIDTH  dividend, two's complement.
- B  input  WIDTH  divisor, two's complement.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; C is valid from this cycle on.
- C  output  2*WIDTH  {remainder, quotient}, held until the next done or clr.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, busy=0, done=0, C=0, all internal registers 0. Reset asserted mid-operation aborts the division; no done is issued.
- States and transitions:
  - IDLE: on an edge with start=1, latch A and B, record sign bits, busy<=1, go to PREP.
  - PREP: replace operands with their magnitudes; partial remainder<=0; cnt<=0; go to ITER.
  - ITER: one non-restoring step per edge.
    - Shift {R,Q} left by 1.
    - If R is non-negative, R = R - |B|; otherwise R = R + |B|.
    - Q[0] = ~R_new[msb].
    - After WIDTH steps, go to FIX.
  - FIX: if R is negative, add |B| back to R.
    - Negate Q if signA differs from signB.
    - Negate R if signA is set.
    - C<={R,Q}, done<=1, busy<=0, go to IDLE.
- Partial remainder is WIDTH+1 bits wide so that sign detection is correct.
- Latency: fixed. done is high during the cycle after the edge that is WIDTH+3 edges after the start-sampling edge (35 for WIDTH=32). busy falls on the same edge that done rises.
- done lasts exactly one cycle. C holds its value until the next FIX or clr.
- Rounding: quotient truncates toward zero. Remainder takes the sign of the dividend. Invariant: A = Q*B + R.
- Divide by zero (B=0, detected in PREP): latency stays the same. Result is Q = all ones, R = A (unsigned magnitude path bypassed; raw A passed through).
- Overflow case, -2^(WIDTH-1) / -1: Q = 0x80000000, R = 0 (magnitudes wrap naturally). No error is signalled.
- start while busy=1 is ignored; in-flight operands are unaffected.
- start in the same cycle that done is high is accepted, because the state is already IDLE.
- A/B may change freely after the sampling edge.

Optional Feature:
- Macro: DIVIDER_DBZ_FLAG_EN.
- When defined:
  - Adds output port dbz (1 bit), reset value 0.
  - dbz is set on the done edge to (B==0) for the completed operation.
  - dbz is held with C until the next done or clr.
- When undefined:
  - No dbz port.
  - Divide-by-zero result is still produced as specified, with no indication.

Test Plan:
- A=100, B=7, start pulse -> done after 35 edges; C=0x00000002_0000000E; busy high for 35 cycles before that.
- A=-100 (0xFFFFFF9C), B=7 -> C=0xFFFFFFFE_FFFFFFF2 (R=-2, Q=-14). Also A=100, B=-7 -> C=0x00000002_FFFFFFF2.
- A=5, B=0 -> C=0x00000005_FFFFFFFF after 35 edges; with DIVIDER_DBZ_FLAG_EN, dbz=1. Next op 9/3 -> C=0x00000000_00000003, dbz=0.
- A=0x80000000, B=0xFFFFFFFF -> C=0x00000000_80000000. A=0, B=5 -> C=0.
- Start 100/7, then re-pulse start with 8/2 at edge 10 -> ignored; result is still 100/7. A start on the done cycle with 8/2 -> C=0x00000000_00000004 after 35 more edges.
- Start 100/7, assert clr asynchronously mid-cycle at edge 12 -> busy, done, C go to 0 immediately; no done follows. After release, 50/5 -> C=0x00000000_0000000A.
